// File: rtl/tc_program_loader_pkg.sv
// Shared types and helpers for the program loader: FSM encoding,
// bytes-per-word derivation and lane-index width.
package tc_program_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int bpw(input int word_width);
        return word_width / 8;
    endfunction

    // Lane counter needs at least one bit even for byte-wide words.
    function automatic int lane_w(input int n_lanes);
        return (n_lanes > 1) ? $clog2(n_lanes) : 1;
    endfunction

endpackage

// File: rtl/tc_byte_packer.sv
// Little-endian byte packer: merges a byte into a lane of the word under
// construction; unfilled lanes read as zero.
// Ports: clk, rst, clr_i (drop partial word), ins_i/lane_i/byte_i (insert),
//        flush_i (emit partial word and clear), word_o (merged word),
//        full_o (this insert fills the top lane).
module tc_byte_packer
    import tc_program_loader_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    localparam int LW = lane_w(bpw(WORD_WIDTH))
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  ins_i,
    input  logic                  flush_i,
    input  logic [LW-1:0]         lane_i,
    input  logic [7:0]            byte_i,
    output logic [WORD_WIDTH-1:0] word_o,
    output logic                  full_o
);

    localparam int BPW = bpw(WORD_WIDTH);
    localparam logic [LW-1:0] TOP_LANE = LW'(BPW - 1);

    logic [WORD_WIDTH-1:0] word_q, word_d;

    // word_o already contains the byte being inserted this cycle, so the
    // caller can latch a complete word on the same edge.
    always_comb begin
        word_o = word_q;
        if (ins_i) begin
            word_o[{lane_i, 3'b000} +: 8] = byte_i;
        end
    end

    assign full_o = ins_i && (lane_i == TOP_LANE);

    always_comb begin
        word_d = word_q;
        if (clr_i || flush_i || full_o) begin
            word_d = '0;
        end else if (ins_i) begin
            word_d = word_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/tc_program_loader.sv
// Program memory writer: packs a valid/ready byte stream into words and
// writes them from a programmable base address.
// Ports: clk, rst (sync, active-high), start, base_addr, byte_in/valid/last,
//        byte_ready, wr_en/wr_addr/wr_data, busy, done, words_written,
//        overflow, checksum.
// Macro TC_PROGRAM_LOADER_CHECKSUM_EN enables the 8-bit byte checksum.
module tc_program_loader
    import tc_program_loader_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int WORD_COUNT = 65536
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    input  logic                  byte_last,
    output logic                  byte_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [WORD_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_written,
    output logic                  overflow,
    output logic [7:0]            checksum
);

    localparam int LW = lane_w(bpw(WORD_WIDTH));
    localparam logic [ADDR_WIDTH:0] MAX_WORDS = (ADDR_WIDTH+1)'(WORD_COUNT);

    state_e                state_q, state_d;
    logic [LW-1:0]         lane_q, lane_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic                  ovf_q, ovf_d;
    logic                  accept, full, clr, insert, flush;
    logic [WORD_WIDTH-1:0] pk_word;
    logic                  pk_full;

    assign accept = byte_valid && (state_q == ST_LOAD);
    assign full   = (words_q == MAX_WORDS);

    tc_byte_packer #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_packer (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .ins_i   (insert),
        .flush_i (flush),
        .lane_i  (lane_q),
        .byte_i  (byte_in),
        .word_o  (pk_word),
        .full_o  (pk_full)
    );

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        ptr_d     = ptr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        words_d   = words_q;
        ovf_d     = ovf_q;
        clr       = 1'b0;
        insert    = 1'b0;
        flush     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    ptr_d   = base_addr;
                    words_d = '0;
                    ovf_d   = 1'b0;
                    lane_d  = '0;
                    clr     = 1'b1;
                end
            end
            ST_LOAD: begin
                if (accept && full) begin
                    // Memory is full: drain the stream, keep nothing.
                    ovf_d = 1'b1;
                    if (byte_last) state_d = ST_DONE;
                end else if (accept) begin
                    insert = 1'b1;
                    lane_d = pk_full ? '0 : lane_q + LW'(1);
                    if (pk_full || byte_last) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = pk_word;
                        ptr_d     = ptr_q + ADDR_WIDTH'(1);
                        words_d   = words_q + (ADDR_WIDTH+1)'(1);
                    end
                    // A partial last word is latched now and strobed
                    // during FLUSH, keeping the one-cycle write latency.
                    if (byte_last) begin
                        flush   = !pk_full;
                        state_d = pk_full ? ST_DONE : ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lane_q    <= '0;
            ptr_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            words_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            ptr_q     <= ptr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            words_q   <= words_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef TC_PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] cks_q;
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cks_q <= '0;
        end else if (accept) begin
            cks_q <= cks_q + byte_in;
        end
    end
    assign checksum = cks_q;
`else
    assign checksum = '0;
`endif

    assign byte_ready    = (state_q == ST_LOAD);
    assign busy          = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
    assign done          = (state_q == ST_DONE);
    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign words_written = words_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_tc_program_loader.sv
// Bench for tc_program_loader: byte-level reference model with a per-cycle
// write comparator, plus literal expectations per directed session.
module tb_tc_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_last = 1'b0;

    logic        byte_ready, wr_en, busy, done, overflow;
    logic [15:0] wr_addr, wr_data;
    logic [16:0] words_written;
    logic [7:0]  checksum;

    logic        o_ready, o_wr_en, o_busy, o_done, o_overflow;
    logic [15:0] o_wr_addr, o_wr_data;
    logic [16:0] o_words;
    logic [7:0]  o_checksum;

    tc_program_loader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_last(byte_last),
        .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done),
        .words_written(words_written), .overflow(overflow),
        .checksum(checksum)
    );

    tc_program_loader #(.WORD_COUNT(2)) dut_o (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_last(byte_last),
        .byte_ready(o_ready), .wr_en(o_wr_en), .wr_addr(o_wr_addr),
        .wr_data(o_wr_data), .busy(o_busy), .done(o_done),
        .words_written(o_words), .overflow(o_overflow),
        .checksum(o_checksum)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    int o_writes = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int          due;
        logic [15:0] a;
        logic [15:0] d;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] obs_a[$];
    logic [15:0] obs_d[$];
    logic [7:0]  stim[$];

    // Reference model state, updated per accepted byte.
    int          m_lane, m_words, m_ptr, m_word, m_sum;
    bit          m_ovf;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic model_start(input logic [15:0] base);
        m_lane = 0; m_words = 0; m_ptr = base; m_word = 0;
        m_sum = 0; m_ovf = 0;
        obs_a.delete(); obs_d.delete();
    endtask

    task automatic model_accept(input logic [7:0] b, input bit last,
                                input int due);
        exp_t e;
        m_sum = (m_sum + b) % 256;
        if (m_words == 65536) begin
            m_ovf = 1;
            return;
        end
        m_word = m_word | (int'(b) << (8 * m_lane));
        m_lane++;
        if (m_lane == 2 || last) begin
            e.due = due; e.a = 16'(m_ptr); e.d = 16'(m_word);
            expq.push_back(e);
            m_ptr = (m_ptr + 1) % 65536;
            m_words++;
            m_word = 0;
            m_lane = 0;
        end
    endtask

    // Per-cycle write comparator for the main instance.
    always @(negedge clk) begin
        bit exp_w;
        exp_w = (expq.size() > 0) && (expq[0].due == edge_n);
        checks++;
        if (wr_en !== exp_w) begin
            errors++;
            $display("FAIL wr_en@%0d: got %0b expected %0b", edge_n, wr_en, exp_w);
        end
        if (wr_en) begin
            obs_a.push_back(wr_addr);
            obs_d.push_back(wr_data);
        end
        if (exp_w) begin
            if (wr_en) begin
                checks++;
                if (wr_addr !== expq[0].a || wr_data !== expq[0].d) begin
                    errors++;
                    $display("FAIL wr_word@%0d: got %h:%h expected %h:%h",
                             edge_n, wr_addr, wr_data, expq[0].a, expq[0].d);
                end
            end
            void'(expq.pop_front());
        end
        if (o_wr_en) o_writes++;
    end

    task automatic start_session(input logic [15:0] base);
        @(posedge clk); #1;
        start = 1'b1; base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
        model_start(base);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last,
                             input bit gap, input bit chk_o);
        bit r;
        int due;
        bit ok;
        if (gap) begin
            byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        byte_valid = 1'b1; byte_in = b; byte_last = last;
        ok = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            r = byte_ready;
            due = edge_n + 1;
            if (chk_o) chk("ovf_ready", o_ready, 1);
            @(posedge clk); #1;
            if (r) begin
                model_accept(b, last, due);
                ok = 1;
                break;
            end
        end
        if (!ok) chk("byte_accept_timeout", 0, 1);
        byte_valid = 1'b0; byte_last = 1'b0;
    endtask

    task automatic run_stream(input logic [15:0] base, input bit gap,
                              input bit chk_o);
        bit seen;
        start_session(base);
        foreach (stim[i]) send_byte(stim[i], i == stim.size() - 1, gap, chk_o);
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            seen = done;
        end
        chk("done_timeout", seen, 1);
        repeat (2) @(negedge clk);
        chk("pending_writes", expq.size(), 0);
        chk("words_written", words_written, m_words);
        chk("done", done, 1);
        chk("busy", busy, 0);
        chk("overflow", overflow, m_ovf);
`ifdef TC_PROGRAM_LOADER_CHECKSUM_EN
        chk("checksum", checksum, m_sum);
`else
        chk("checksum", checksum, 0);
`endif
    endtask

    task automatic chk_word(input int i, input logic [15:0] a,
                            input logic [15:0] d);
        chk("obs_count", obs_a.size() > i, 1);
        if (obs_a.size() > i) begin
            chk("obs_addr", obs_a[i], a);
            chk("obs_data", obs_d[i], d);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", byte_ready, 0);
        chk("rst_words", words_written, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_checksum", checksum, 0);
    endtask

    initial begin
        int w0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs();

        stim = '{8'h34, 8'h12, 8'h78, 8'h56};
        run_stream(16'h0010, 0, 0);
        chk("basic_n", obs_a.size(), 2);
        chk_word(0, 16'h0010, 16'h1234);
        chk_word(1, 16'h0011, 16'h5678);
        chk("basic_ww", words_written, 2);

        stim = '{8'hAA, 8'hBB, 8'hCC};
        run_stream(16'h0100, 0, 0);
        chk("odd_n", obs_a.size(), 2);
        chk_word(0, 16'h0100, 16'hBBAA);
        chk_word(1, 16'h0101, 16'h00CC);
        chk("odd_ww", words_written, 2);

        stim = '{8'h34, 8'h12, 8'h78, 8'h56};
        run_stream(16'h0010, 1, 0);
        chk("gap_n", obs_a.size(), 2);
        chk_word(0, 16'h0010, 16'h1234);
        chk_word(1, 16'h0011, 16'h5678);

        stim = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_stream(16'hFFFF, 0, 0);
        chk_word(0, 16'hFFFF, 16'h2211);
        chk_word(1, 16'h0000, 16'h4433);
        chk("wrap_ovf", overflow, 0);

        stim = '{8'h5A};
        run_stream(16'h0030, 0, 0);
        chk("empty_n", obs_a.size(), 1);
        chk_word(0, 16'h0030, 16'h005A);

        w0 = o_writes;
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hF6};
        run_stream(16'h0040, 0, 1);
        chk("ovf_writes", o_writes - w0, 2);
        chk("ovf_flag", o_overflow, 1);
        chk("ovf_done", o_done, 1);
        chk("ovf_words", o_words, 2);
`ifdef TC_PROGRAM_LOADER_CHECKSUM_EN
        chk("ovf_checksum", o_checksum, 8'h05);
`else
        chk("ovf_checksum", o_checksum, 0);
`endif
        chk("main_n", obs_a.size(), 3);

        start_session(16'h0200);
        send_byte(8'hEE, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        repeat (3) @(negedge clk);
        chk("rst_idle_wr_en", wr_en, 0);

        stim = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_stream(16'h0300, 0, 0);
        chk_word(0, 16'h0300, 16'h0201);
        chk_word(1, 16'h0301, 16'h0403);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tc_program_loader.md
Name: tc_program_loader

Overview:
- Writer side of the program memory. Accepts a valid/ready byte stream from the host or a debug link.
- Packs bytes little-endian (first byte into [7:0]) into WORD_WIDTH words.
- Issues single-cycle write strobes into the program memory's write port, starting at a programmable base address.
- Reports completion, word count and overflow to the control logic that holds the CPU in reset during load.

Parameters:
- WORD_WIDTH, 16, program word width; must be a multiple of 8.
- ADDR_WIDTH, 16, program memory address width.
- WORD_COUNT, 65536, maximum words accepted per load session.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a load session when in IDLE or DONE.
- base_addr  in  ADDR_WIDTH  first write address; sampled on accepted start.
- byte_in  in  8  stream data.
- byte_valid  in  1  stream data valid.
- byte_last  in  1  marks final byte of the stream; qualified by byte_valid.
- byte_ready  out  1  loader accepts byte_in this cycle.
- wr_en  out  1  one-cycle write strobe to program memory.
- wr_addr  out  ADDR_WIDTH  write address.
- wr_data  out  WORD_WIDTH  write data.
- busy  out  1  session active (LOAD or FLUSH).
- done  out  1  session finished; level, held until start or rst.
- words_written  out  ADDR_WIDTH+1  words committed this session.
- overflow  out  1  sticky: bytes arrived after WORD_COUNT words were written.
- checksum  out  8  see Optional Feature.

Behaviour:
- Reset: all outputs 0, state IDLE, byte lane 0, packer cleared. rst mid-session aborts immediately; any partial word is discarded and no further wr_en is issued.
- Derived constant: BPW = WORD_WIDTH/8.
- FSM states and transitions:
  - IDLE: byte_ready=0. start -> LOAD next cycle; ptr=base_addr, words_written=0, overflow=0, lane=0.
  - LOAD: byte_ready=1, busy=1.
    - Handshake: a byte is accepted when byte_valid && byte_ready. byte_valid without ready is held by the source.
    - Accepted byte fills lane L: bits [8L+7:8L]. L increments, wrapping at BPW.
    - If L==BPW-1: next cycle wr_en=1, wr_addr=ptr, wr_data=packed word; then ptr+=1, words_written+=1.
    - If byte_last is accepted: go to FLUSH when the word is partial (L<BPW-1), else go to DONE after the write.
  - FLUSH: byte_ready=0. Writes the partial word with unfilled upper lanes zero-padded, one wr_en cycle. Then DONE.
  - DONE: byte_ready=0, busy=0, done=1. start -> LOAD, same initialisation as from IDLE.
- start while in LOAD or FLUSH is ignored.
- Latency: wr_en is asserted exactly 1 cycle after the byte that completes a word. Sustained throughput is one byte per cycle.
- Address wrap: ptr increments modulo 2^ADDR_WIDTH (0xFFFF -> 0x0000), with no error flagged.
- Full condition: once words_written==WORD_COUNT, further accepted bytes are dropped (no wr_en) and overflow is set.
  - byte_ready stays 1 so the stream drains until byte_last.
  - In this case byte_last goes directly to DONE; there is no FLUSH write.
- Empty session (byte_last on the first byte, BPW>1): one zero-padded word is written.
- wr_data and wr_addr hold their last values when wr_en=0.

Optional Feature:
- Macro TC_PROGRAM_LOADER_CHECKSUM_EN.
- Defined: checksum is the 8-bit modulo-256 sum of every accepted byte this session, including dropped overflow bytes. It is cleared on start and on rst, and is valid when done=1.
- Undefined: checksum tied to 0 and no adder is synthesised.

Decomposition:
- Package tc_program_loader_pkg:
  - FSM state encodings (IDLE=0, LOAD=1, FLUSH=2, DONE=3).
  - BPW derivation.
  - Lane-index width function.
- Sub-module tc_byte_packer, parameterised on WORD_WIDTH:
  - Inputs: lane-indexed byte insert, clear, zero-pad flush.
  - Outputs: packed word and a word-complete flag.
- The top level keeps the FSM, address pointer, counters and checksum.

Test Plan:
- Basic load: base=0x0010, bytes 0x34,0x12,0x78,0x56 (last on 0x56) -> wr_en at 0x0010=0x1234 and 0x0011=0x5678, each 1 cycle after the completing byte; words_written=2; done=1.
- Odd length: bytes 0xAA,0xBB,0xCC (last) -> writes 0xBBAA then FLUSH writes 0x00CC; words_written=2.
- Backpressure/gaps: byte_valid toggled every other cycle -> data identical to the gap-free case and no duplicate writes.
- Wrap: base=0xFFFF, 4 bytes -> writes at 0xFFFF then 0x0000; overflow=0.
- Overflow: WORD_COUNT=2, 6 bytes -> 2 writes only, overflow=1, byte_ready=1 until last, done=1. With the macro defined, checksum equals the sum of all 6 bytes.
- Reset mid-word: rst after the first byte of a word -> no wr_en, all outputs 0. A following start loads cleanly from the new base.
